// File: rtl/note_player_scheduler_pkg.sv
// Shared definitions for the song-player note scheduler: mode encodings,
// note/duration widths and the bit layout of a song_note word.
package note_player_scheduler_pkg;

  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int DUR_MSB  = 11;
  localparam int DUR_LSB  = 6;
  localparam int NOTE_MSB = 5;

  typedef enum logic [1:0] {
    JAM_SESH    = 2'b00,
    COMPOSER    = 2'b01,
    SONG_PLAYER = 2'b10
  } mode_e;

  typedef enum logic {
    NP_IDLE    = 1'b0,
    NP_PLAYING = 1'b1
  } player_state_e;

endpackage

// File: rtl/note_player_scheduler_np_duration_counter.sv
// One note player's lifetime: holds the remaining beat count while playing
// and emits a registered one-cycle release when it expires or is flushed.
module np_duration_counter
  import note_player_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DUR_W-1:0] duration_i,
  input  logic             tick_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             release_o
);

  player_state_e    state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             release_q, release_d;

  // A load never coincides with a decrement: the player is idle on the load edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    release_d = 1'b0;
    case (state_q)
      NP_IDLE: begin
        if (load_i && !flush_i) begin
          state_d = NP_PLAYING;
          cnt_d   = duration_i;
        end
      end
      NP_PLAYING: begin
        if (flush_i) begin
          state_d   = NP_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (tick_i) begin
          if (cnt_q <= DUR_W'(1)) begin
            state_d   = NP_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
      default: begin
        state_d = NP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= NP_IDLE;
      cnt_q     <= '0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      release_q <= release_d;
    end
  end

  assign busy_o    = (state_q == NP_PLAYING);
  assign release_o = release_q;

endmodule

// File: rtl/note_player_scheduler.sv
// Assigns incoming song notes to the lowest-index free note player and
// presents a registered load/note/busy/release interface to the synth.
module note_player_scheduler
  import note_player_scheduler_pkg::*;
#(
  parameter int NUM_PLAYERS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    state,
  input  logic                          play,
  input  logic                          beat,
  input  logic                          load_new_note,
  input  logic [DUR_W+NOTE_W-1:0]       song_note,
  output logic [NUM_PLAYERS-1:0]        np_load,
  output logic [NUM_PLAYERS*NOTE_W-1:0] np_note,
  output logic [NUM_PLAYERS-1:0]        np_busy,
  output logic [NUM_PLAYERS-1:0]        np_release,
  output logic                          all_busy,
  output logic                          note_dropped
);

  logic                          active;
  logic                          tick;
  logic                          loadValid;
  logic [NOTE_W-1:0]             noteVal;
  logic [DUR_W-1:0]              durVal;
  logic [NUM_PLAYERS-1:0]        grant;
  logic                          freeFound;
  logic [NUM_PLAYERS-1:0]        loadVec;
  logic [NUM_PLAYERS-1:0]        np_load_q, np_load_d;
  logic [NUM_PLAYERS*NOTE_W-1:0] np_note_q, np_note_d;
  logic                          note_dropped_q, note_dropped_d;

  assign active    = (state == SONG_PLAYER);
  assign tick      = beat & play & active;
  assign noteVal   = song_note[NOTE_MSB:0];
  assign durVal    = song_note[DUR_MSB:DUR_LSB];
  assign loadValid = load_new_note & active & (|noteVal) & (|durVal);

  // Busy flags are registered, so a player releasing on this edge still looks taken.
  always_comb begin
    grant     = '0;
    freeFound = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!np_busy[i] && !freeFound) begin
        grant[i]  = 1'b1;
        freeFound = 1'b1;
      end
    end
  end

  always_comb begin
    loadVec        = loadValid ? grant : '0;
    note_dropped_d = loadValid & ~freeFound;
    np_load_d      = loadVec;
    np_note_d      = np_note_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (loadVec[i]) np_note_d[i*NOTE_W +: NOTE_W] = noteVal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      np_load_q      <= '0;
      np_note_q      <= '0;
      note_dropped_q <= 1'b0;
    end else begin
      np_load_q      <= np_load_d;
      np_note_q      <= np_note_d;
      note_dropped_q <= note_dropped_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gPlayer
    np_duration_counter uCounter (
      .clk       (clk),
      .reset     (reset),
      .load_i    (loadVec[g]),
      .duration_i(durVal),
      .tick_i    (tick),
      .flush_i   (!active),
      .busy_o    (np_busy[g]),
      .release_o (np_release[g])
    );
  end

  assign np_load      = np_load_q;
  assign np_note      = np_note_q;
  assign note_dropped = note_dropped_q;
  assign all_busy     = &np_busy;

endmodule

// File: tb/tb_note_player_scheduler.sv
// Self-checking bench for note_player_scheduler: directed scenarios followed by
// randomized traffic, all compared against a per-player remaining-beats model.
module tb_note_player_scheduler;

  localparam logic [1:0] JAM = 2'b00;
  localparam logic [1:0] CMP = 2'b01;
  localparam logic [1:0] SP  = 2'b10;

  logic        clk;
  logic        reset;
  logic [1:0]  state;
  logic        play;
  logic        beat;
  logic        load_new_note;
  logic [11:0] song_note;
  logic [2:0]  np_load;
  logic [17:0] np_note;
  logic [2:0]  np_busy;
  logic [2:0]  np_release;
  logic        all_busy;
  logic        note_dropped;

  int          checks = 0;
  int          errors = 0;

  // Reference model: remaining beats per player plus the pulses expected after the edge.
  int          remaining[3];
  logic [2:0]  mBusy   = '0;
  logic [2:0]  expLoad = '0;
  logic [2:0]  expRel  = '0;
  logic        expDrop = 1'b0;
  logic [17:0] expNote = '0;

  note_player_scheduler #(.NUM_PLAYERS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .state        (state),
    .play         (play),
    .beat         (beat),
    .load_new_note(load_new_note),
    .song_note    (song_note),
    .np_load      (np_load),
    .np_note      (np_note),
    .np_busy      (np_busy),
    .np_release   (np_release),
    .all_busy     (all_busy),
    .note_dropped (note_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("np_load", np_load, expLoad);
    checkValue("np_busy", np_busy, mBusy);
    checkValue("np_release", np_release, expRel);
    checkValue("np_note", np_note, expNote);
    checkValue("all_busy", all_busy, &mBusy);
    checkValue("note_dropped", note_dropped, expDrop);
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks #1 later.
  task automatic applyStimulus(input logic rst, input logic [1:0] st, input logic pl,
                               input logic bt, input logic ld, input logic [5:0] dur,
                               input logic [5:0] nt);
    logic [2:0] busyBefore;
    bit         found;
    reset         = rst;
    state         = st;
    play          = pl;
    beat          = bt;
    load_new_note = ld;
    song_note     = {dur, nt};
    expLoad = '0;
    expRel  = '0;
    expDrop = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 3; i++) remaining[i] = 0;
      mBusy   = '0;
      expNote = '0;
    end else if (st != SP) begin
      expRel = mBusy;
      mBusy  = '0;
      for (int i = 0; i < 3; i++) remaining[i] = 0;
    end else begin
      busyBefore = mBusy;
      if (bt && pl) begin
        for (int i = 0; i < 3; i++) begin
          if (mBusy[i]) begin
            remaining[i] = remaining[i] - 1;
            if (remaining[i] == 0) begin
              mBusy[i]  = 1'b0;
              expRel[i] = 1'b1;
            end
          end
        end
      end
      if (ld && dur != 0 && nt != 0) begin
        found = 0;
        for (int i = 0; i < 3; i++) begin
          if (!busyBefore[i] && !found) begin
            found             = 1;
            mBusy[i]          = 1'b1;
            remaining[i]      = int'(dur);
            expNote[i*6 +: 6] = nt;
            expLoad[i]        = 1'b1;
          end
        end
        if (!found) expDrop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [1:0] rSt;
    for (int i = 0; i < 3; i++) remaining[i] = 0;
    reset = 1'b0; state = SP; play = 1'b1; beat = 1'b0;
    load_new_note = 1'b0; song_note = '0;

    // Reset held with a pending load
    applyStimulus(0, SP, 1, 1, 1, 6'd3, 6'd9);
    applyStimulus(0, SP, 1, 1, 1, 6'd3, 6'd9);
    checkValue("reset_busy", np_busy, 3'b000);
    checkValue("reset_note", np_note, 18'd0);
    applyStimulus(1, SP, 1, 0, 0, 6'd0, 6'd0);
    checkValue("post_reset_busy", np_busy, 3'b000);

    // Single note of 2 beats
    applyStimulus(1, SP, 1, 0, 1, 6'd2, 6'd4);
    checkValue("single_load", np_load, 3'b001);
    checkValue("single_note", np_note[5:0], 6'd4);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("single_mid_rel", np_release, 3'b000);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("single_release", np_release, 3'b001);
    applyStimulus(1, SP, 1, 0, 0, 6'd0, 6'd0);
    checkValue("single_idle", np_busy, 3'b000);

    // Chord, then a fourth note that must be dropped
    applyStimulus(1, SP, 1, 0, 1, 6'd63, 6'd4);
    checkValue("chord_load0", np_load, 3'b001);
    applyStimulus(1, SP, 1, 0, 1, 6'd39, 6'd6);
    checkValue("chord_load1", np_load, 3'b010);
    applyStimulus(1, SP, 1, 0, 1, 6'd33, 6'd8);
    checkValue("chord_load2", np_load, 3'b100);
    checkValue("chord_all_busy", all_busy, 1'b1);
    applyStimulus(1, SP, 1, 0, 1, 6'd5, 6'd10);
    checkValue("chord_dropped", note_dropped, 1'b1);
    checkValue("chord_drop_noload", np_load, 3'b000);
    checkValue("chord_notes", np_note, {6'd8, 6'd6, 6'd4});

    // Leaving SONG_PLAYER flushes every player; loads then ignored
    applyStimulus(1, JAM, 1, 0, 0, 6'd0, 6'd0);
    checkValue("flush_release", np_release, 3'b111);
    checkValue("flush_busy", np_busy, 3'b000);
    applyStimulus(1, JAM, 1, 1, 1, 6'd4, 6'd12);
    checkValue("inactive_noload", np_load, 3'b000);
    applyStimulus(1, CMP, 1, 0, 1, 6'd4, 6'd12);

    // Pause freezes the countdown
    applyStimulus(1, SP, 1, 0, 1, 6'd3, 6'd4);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1, SP, 0, 1, 0, 6'd0, 6'd0);
    checkValue("pause_busy", np_busy, 3'b001);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("pause_no_rel", np_release, 3'b000);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("pause_release", np_release, 3'b001);

    // Load on a beat edge still needs the full duration
    applyStimulus(1, SP, 1, 1, 1, 6'd2, 6'd5);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("loadbeat_hold", np_busy, 3'b001);
    applyStimulus(1, SP, 1, 1, 0, 6'd0, 6'd0);
    checkValue("loadbeat_release", np_release, 3'b001);

    // Player 0 expiring on the same edge as a load: load goes to player 1
    applyStimulus(1, SP, 1, 0, 1, 6'd1, 6'd3);
    applyStimulus(1, SP, 1, 1, 1, 6'd4, 6'd9);
    checkValue("samedge_load", np_load, 3'b010);
    checkValue("samedge_release", np_release, 3'b001);
    applyStimulus(1, JAM, 1, 0, 0, 6'd0, 6'd0);

    // Rests allocate nothing and are not drops
    applyStimulus(1, SP, 1, 0, 1, 6'd0, 6'd7);
    checkValue("rest_dur_load", {np_load, note_dropped}, 4'b0000);
    applyStimulus(1, SP, 1, 0, 1, 6'd5, 6'd0);
    checkValue("rest_note_load", {np_load, note_dropped}, 4'b0000);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 19))
        0:       rSt = JAM;
        1:       rSt = CMP;
        default: rSt = SP;
      endcase
      applyStimulus(($urandom_range(0, 99) != 0), rSt,
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 6)),
                    ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
